// File: rtl/pcm_seq_pkg.sv
// Shared types and defaults for the PCM record/playback sequencer.
package pcm_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_REC_WR,
        S_REC_HOLD,
        S_PLAY,
        S_PLAY_RD,
        S_PLAY_HOLD
    } seq_state_t;

    localparam int ABITS_DEFAULT = 7;
    localparam int HOLD_DEFAULT  = 4;

    // True while a FIFO access is in flight and a new tick cannot be served.
    function automatic logic is_access(input seq_state_t s);
        return (s == S_REC_WR) || (s == S_REC_HOLD) ||
               (s == S_PLAY_RD) || (s == S_PLAY_HOLD);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous button level.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [2:0] sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], btn};
        end
    end

    assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/pcm_fifo_seq.sv
// Record/playback sequencer sharing one 1-bit sample FIFO; issues pulse strobes and tracks fill level.
//
// state       | meaning
// S_IDLE      | no activity, audio_out held at 0
// S_REC       | recording, waiting for a sample tick
// S_REC_WR    | fifo_wr strobe cycle
// S_REC_HOLD  | waiting for the FIFO to commit the write
// S_PLAY      | playing, waiting for a sample tick
// S_PLAY_RD   | fifo_rd strobe cycle
// S_PLAY_HOLD | waiting for fifo_dout to become valid
module pcm_fifo_seq
    import pcm_seq_pkg::*;
#(
    parameter int ABITS = ABITS_DEFAULT,
    parameter int HOLD  = HOLD_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rec_btn,
    input  logic           play_btn,
    input  logic           sample_tick,
    input  logic           mic_bit,
    input  logic           fifo_full,
    input  logic           fifo_empty,
    input  logic           fifo_dout,
    output logic           fifo_wr,
    output logic           fifo_rd,
    output logic           fifo_din,
    output logic           audio_out,
    output logic           recording,
    output logic           playing,
    output logic           overrun,
    output logic [ABITS:0] level
);

    localparam int             CW        = $clog2(HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD - 1);
    localparam logic [ABITS:0] LVL_MAX   = {1'b1, {ABITS{1'b0}}};

    seq_state_t    state;
    logic [CW-1:0] hold_cnt;
    logic          stop_req;
    logic          rec_pulse;
    logic          play_pulse;

    btn_edge u_rec_edge (
        .clock (clock),
        .reset (reset),
        .btn   (rec_btn),
        .pulse (rec_pulse)
    );

    btn_edge u_play_edge (
        .clock (clock),
        .reset (reset),
        .btn   (play_btn),
        .pulse (play_pulse)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            stop_req  <= 1'b0;
            fifo_wr   <= 1'b0;
            fifo_rd   <= 1'b0;
            fifo_din  <= 1'b0;
            audio_out <= 1'b0;
            recording <= 1'b0;
            playing   <= 1'b0;
            overrun   <= 1'b0;
            level     <= '0;
        end else begin
            fifo_wr <= 1'b0;
            fifo_rd <= 1'b0;
            if (is_access(state) && sample_tick) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    audio_out <= 1'b0;
                    stop_req  <= 1'b0;
                    if (rec_pulse) begin
                        state     <= S_REC;
                        recording <= 1'b1;
                        overrun   <= 1'b0;
                    end else if (play_pulse && (level != '0)) begin
                        state   <= S_PLAY;
                        playing <= 1'b1;
                        overrun <= 1'b0;
                    end
                end

                S_REC: begin
                    if (rec_pulse || (sample_tick && (fifo_full || level == LVL_MAX))) begin
                        state     <= S_IDLE;
                        recording <= 1'b0;
                    end else if (sample_tick) begin
                        fifo_din <= mic_bit;
                        fifo_wr  <= 1'b1;
                        state    <= S_REC_WR;
                    end
                end

                S_REC_WR: begin
                    if (level != LVL_MAX) begin
                        level <= level + 1'b1;
                    end
                    if (rec_pulse) begin
                        stop_req <= 1'b1;
                    end
                    hold_cnt <= HOLD_LAST;
                    state    <= S_REC_HOLD;
                end

                S_REC_HOLD: begin
                    if (rec_pulse) begin
                        stop_req <= 1'b1;
                    end
                    if (hold_cnt == '0) begin
                        if (stop_req || rec_pulse) begin
                            state     <= S_IDLE;
                            recording <= 1'b0;
                            stop_req  <= 1'b0;
                        end else begin
                            state <= S_REC;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                S_PLAY: begin
                    if (play_pulse || (sample_tick && (fifo_empty || level == '0))) begin
                        state     <= S_IDLE;
                        playing   <= 1'b0;
                        audio_out <= 1'b0;
                    end else if (sample_tick) begin
                        fifo_rd <= 1'b1;
                        state   <= S_PLAY_RD;
                    end
                end

                S_PLAY_RD: begin
                    if (level != '0) begin
                        level <= level - 1'b1;
                    end
                    if (play_pulse) begin
                        stop_req <= 1'b1;
                    end
                    hold_cnt <= HOLD_LAST;
                    state    <= S_PLAY_HOLD;
                end

                S_PLAY_HOLD: begin
                    if (play_pulse) begin
                        stop_req <= 1'b1;
                    end
                    if (hold_cnt == '0) begin
                        // Stopping here lands in IDLE, where audio must read 0.
                        if (stop_req || play_pulse) begin
                            state     <= S_IDLE;
                            playing   <= 1'b0;
                            audio_out <= 1'b0;
                            stop_req  <= 1'b0;
                        end else begin
                            state     <= S_PLAY;
                            audio_out <= fifo_dout;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    recording <= 1'b0;
                    playing   <= 1'b0;
                    audio_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_fifo_seq.sv
// Directed bench for pcm_fifo_seq with a behavioural 128x1 FIFO attached.
module tb_pcm_fifo_seq;

    localparam int ABITS = 7;
    localparam int HOLD  = 4;
    localparam int DEPTH = 128;

    logic         clock;
    logic         reset;
    logic         rec_btn;
    logic         play_btn;
    logic         sample_tick;
    logic         mic_bit;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_dout;
    logic         fifo_wr;
    logic         fifo_rd;
    logic         fifo_din;
    logic         audio_out;
    logic         recording;
    logic         playing;
    logic         overrun;
    logic [ABITS:0] level;

    int checks = 0;
    int errors = 0;
    int wr_cnt;
    int fcnt;
    logic q[$];
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    pcm_fifo_seq #(.ABITS(ABITS), .HOLD(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .rec_btn     (rec_btn),
        .play_btn    (play_btn),
        .sample_tick (sample_tick),
        .mic_bit     (mic_bit),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_wr     (fifo_wr),
        .fifo_rd     (fifo_rd),
        .fifo_din    (fifo_din),
        .audio_out   (audio_out),
        .recording   (recording),
        .playing     (playing),
        .overrun     (overrun),
        .level       (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            fcnt      <= 0;
            fifo_dout <= 1'b0;
            wr_cnt    <= 0;
        end else begin
            if (fifo_wr) begin
                wr_cnt <= wr_cnt + 1;
                if (q.size() < DEPTH) q.push_back(fifo_din);
            end
            if (fifo_rd && q.size() > 0) fifo_dout <= q.pop_front();
            fcnt <= q.size();
        end
    end

    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic r, input logic p);
        rec_btn  = r;
        play_btn = p;
        step(4);
        rec_btn  = 1'b0;
        play_btn = 1'b0;
        step(4);
    endtask

    task automatic tick(input logic b);
        mic_bit     = b;
        sample_tick = 1'b1;
        @(posedge clock);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_reset();
        do_reset();
        step(20);
        checks++;
        if ({fifo_wr, fifo_rd, fifo_din, audio_out, recording, playing, overrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000000",
                     {fifo_wr, fifo_rd, fifo_din, audio_out, recording, playing, overrun});
        end
        checks++;
        if (level !== 8'd0) begin
            errors++;
            $display("FAIL reset_level got %0d exp 0", level);
        end
    endtask

    task automatic test_record();
        int base;
        press(1'b1, 1'b0);
        checks++;
        if (recording !== 1'b1) begin
            errors++;
            $display("FAIL rec_enter got %b exp 1", recording);
        end
        base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            tick(pat[i]);
            @(negedge clock);
            checks++;
            if (fifo_wr !== 1'b1 || fifo_din !== pat[i]) begin
                errors++;
                $display("FAIL rec_wr_%0d got wr=%b din=%b exp wr=1 din=%b", i, fifo_wr, fifo_din, pat[i]);
            end
            @(negedge clock);
            checks++;
            if (fifo_wr !== 1'b0) begin
                errors++;
                $display("FAIL rec_wr_low_%0d got %b exp 0", i, fifo_wr);
            end
            @(posedge clock);
            #1;
            step(5);
        end
        checks++;
        if (level !== 8'd5 || (wr_cnt - base) !== 5) begin
            errors++;
            $display("FAIL rec_level got level=%0d writes=%0d exp 5 5", level, wr_cnt - base);
        end
        press(1'b1, 1'b0);
        checks++;
        if (recording !== 1'b0 || level !== 8'd5) begin
            errors++;
            $display("FAIL rec_stop got rec=%b level=%0d exp 0 5", recording, level);
        end
    endtask

    task automatic test_playback();
        logic prev;
        prev = 1'b0;
        press(1'b0, 1'b1);
        checks++;
        if (playing !== 1'b1) begin
            errors++;
            $display("FAIL play_enter got %b exp 1", playing);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            @(negedge clock);
            checks++;
            if (fifo_rd !== 1'b1) begin
                errors++;
                $display("FAIL play_rd_%0d got %b exp 1", i, fifo_rd);
            end
            @(negedge clock);
            checks++;
            if (fifo_rd !== 1'b0) begin
                errors++;
                $display("FAIL play_rd_low_%0d got %b exp 0", i, fifo_rd);
            end
            repeat (3) @(negedge clock);
            checks++;
            if (audio_out !== prev) begin
                errors++;
                $display("FAIL play_audio_early_%0d got %b exp %b", i, audio_out, prev);
            end
            @(negedge clock);
            checks++;
            if (audio_out !== pat[i]) begin
                errors++;
                $display("FAIL play_audio_%0d got %b exp %b", i, audio_out, pat[i]);
            end
            prev = pat[i];
            @(posedge clock);
            #1;
            step(1);
        end
        checks++;
        if (level !== 8'd0) begin
            errors++;
            $display("FAIL play_level got %0d exp 0", level);
        end
        tick(1'b0);
        @(negedge clock);
        checks++;
        if (playing !== 1'b0 || audio_out !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL play_empty got play=%b audio=%b rd=%b exp 0 0 0", playing, audio_out, fifo_rd);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_fill();
        int base;
        do_reset();
        press(1'b1, 1'b0);
        base = wr_cnt;
        for (int i = 0; i < 130; i++) begin
            tick(i[0] ^ i[2]);
            step(7);
        end
        checks++;
        if ((wr_cnt - base) !== DEPTH) begin
            errors++;
            $display("FAIL fill_writes got %0d exp %0d", wr_cnt - base, DEPTH);
        end
        checks++;
        if (level !== 8'd128 || recording !== 1'b0) begin
            errors++;
            $display("FAIL fill_state got level=%0d rec=%b exp 128 0", level, recording);
        end
    endtask

    task automatic test_overrun();
        int base;
        do_reset();
        press(1'b1, 1'b0);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_initial got %b exp 0", overrun);
        end
        base = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            step(2);
        end
        step(8);
        checks++;
        if (overrun !== 1'b1 || (wr_cnt - base) !== 2 || level !== 8'd2) begin
            errors++;
            $display("FAIL ovr_set got ovr=%b writes=%0d level=%0d exp 1 2 2", overrun, wr_cnt - base, level);
        end
        press(1'b1, 1'b0);
        checks++;
        if (recording !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got rec=%b ovr=%b exp 0 1", recording, overrun);
        end
        press(1'b1, 1'b0);
        checks++;
        if (recording !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got rec=%b ovr=%b exp 1 0", recording, overrun);
        end
        press(1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(1'b1, 1'b1);
        checks++;
        if (recording !== 1'b1 || playing !== 1'b0) begin
            errors++;
            $display("FAIL simul_press got rec=%b play=%b exp 1 0", recording, playing);
        end
        press(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        press(1'b1, 1'b0);
        tick(1'b1);
        step(8);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        checks++;
        if (playing !== 1'b1 || level !== 8'd1) begin
            errors++;
            $display("FAIL hold_setup got play=%b level=%0d exp 1 1", playing, level);
        end
        tick(1'b0);
        step(2);
        reset = 1'b0;
        #1;
        checks++;
        if (playing !== 1'b0 || fifo_rd !== 1'b0 || audio_out !== 1'b0 || level !== 8'd0) begin
            errors++;
            $display("FAIL hold_reset got play=%b rd=%b audio=%b level=%0d exp 0 0 0 0",
                     playing, fifo_rd, audio_out, level);
        end
        step(2);
        reset = 1'b1;
        step(3);
        press(1'b0, 1'b1);
        checks++;
        if (playing !== 1'b0 || recording !== 1'b0) begin
            errors++;
            $display("FAIL hold_after got play=%b rec=%b exp 0 0", playing, recording);
        end
    endtask

    initial begin
        reset       = 1'b0;
        rec_btn     = 1'b0;
        play_btn    = 1'b0;
        sample_tick = 1'b0;
        mic_bit     = 1'b0;
        test_reset();
        test_record();
        test_playback();
        test_fill();
        test_overrun();
        test_simultaneous();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
